// File: rtl/commit_unit.sv
// In-order commit/writeback stage for a fine-grained multithreaded pipeline:
// per-thread PC tracking, replay, register writes, redirects and a store queue.
module commit_unit #(
    parameter int N_THREADS = 8,
    parameter int XLEN = 32,
    parameter int PADDR_W = 20,
    parameter int SQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 'h1000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wb_valid,
    input  logic [$clog2(N_THREADS)-1:0]        wb_thread,
    input  logic [XLEN-1:0]                     wb_pc,
    input  logic                                wb_isvalid,
    input  logic                                wb_flag_reg,
    input  logic                                wb_flag_mul,
    input  logic [4:0]                          wb_dst,
    input  logic [XLEN-1:0]                     wb_data,
    input  logic [XLEN-1:0]                     wb_mul,
    input  logic [XLEN-1:0]                     wb_r2,
    input  logic                                wb_flag_jump,
    input  logic                                wb_flag_branch,
    input  logic                                wb_isequal,
    input  logic                                wb_flag_store,
    input  logic                                wb_flag_isbyte,
    output logic [N_THREADS*XLEN-1:0]           pc_o,
    output logic                                rf_wen,
    output logic [$clog2(N_THREADS)-1:0]        rf_thread,
    output logic [4:0]                          rf_addr,
    output logic [XLEN-1:0]                     rf_wdata,
    output logic                                st_valid,
    input  logic                                st_ready,
    output logic [PADDR_W-1:0]                  st_addr,
    output logic [XLEN-1:0]                     st_data,
    output logic                                st_isbyte,
    output logic [$clog2(SQ_DEPTH+1)-1:0]       sq_count
);

    localparam int TID_W = $clog2(N_THREADS);
    localparam int CNT_W = $clog2(SQ_DEPTH + 1);
    localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SQ_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SQ_DEPTH);

    logic [XLEN-1:0]    pc         [N_THREADS];
    logic [XLEN-1:0]    waiting_pc [N_THREADS];

    logic [PADDR_W-1:0] sq_addr    [SQ_DEPTH];
    logic [XLEN-1:0]    sq_data    [SQ_DEPTH];
    logic               sq_isbyte  [SQ_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [XLEN-1:0]    cur_wpc;
    logic [XLEN-1:0]    next_pc;
    logic               match;
    logic               sq_full;
    logic               commit;
    logic               replay;
    logic               taken;
    logic               push;
    logic               pop;
    logic               rf_write;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Fullness is judged on the pre-pop count: a draining head never makes room
    // for a same-cycle push, so a store against a full queue always replays.
    always_comb begin
        cur_wpc  = waiting_pc[wb_thread];
        match    = wb_valid && (wb_pc == cur_wpc);
        sq_full  = (count == FULL_CNT);
        commit   = match && wb_isvalid && !(wb_flag_store && sq_full);
        replay   = match && !commit;
        taken    = wb_flag_jump && (!wb_flag_branch || wb_isequal);
        next_pc  = taken ? wb_data : cur_wpc + XLEN'(4);
        push     = commit && wb_flag_store;
        pop      = (count != '0) && st_ready;
        rf_write = commit && wb_flag_reg && (wb_dst != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                pc[i]         <= RESET_PC;
                waiting_pc[i] <= RESET_PC;
            end
        end else if (commit) begin
            pc[wb_thread]         <= next_pc;
            waiting_pc[wb_thread] <= next_pc;
        end else if (replay) begin
            pc[wb_thread] <= cur_wpc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_thread <= '0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
        end else begin
            rf_wen <= rf_write;
            if (rf_write) begin
                rf_thread <= wb_thread;
                rf_addr   <= wb_dst;
                rf_wdata  <= wb_flag_mul ? wb_mul : wb_data;
            end
        end
    end

    // Store queue handshake: the head is offered while st_valid is high and
    // leaves the queue on any cycle where st_valid && st_ready; until then the
    // head fields stay stable. st_ready with an empty queue is ignored.
    always_ff @(posedge clk) begin
        if (push) begin
            sq_addr[tail]   <= wb_data[PADDR_W-1:0];
            sq_data[tail]   <= wb_r2;
            sq_isbyte[tail] <= wb_flag_isbyte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        pc_o = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            pc_o[i*XLEN +: XLEN] = pc[i];
        end
    end

    assign sq_count  = count;
    assign st_valid  = (count != '0);
    assign st_addr   = st_valid ? sq_addr[head]   : '0;
    assign st_data   = st_valid ? sq_data[head]   : '0;
    assign st_isbyte = st_valid ? sq_isbyte[head] : 1'b0;

    logic unused_tid_w;
    assign unused_tid_w = (TID_W == 0);

endmodule
